// File: rtl/bnn_seq_pkg.sv
// Shared constants, state encoding and score type for the BNN frame sequencer.
// The optional full-score result port is enabled with `define BNN_SEQ_SCORES_EN.
package bnn_seq_pkg;

  localparam int IMG_W       = 64;
  localparam int IMG_H       = 64;
  localparam int N_CLASS     = 3;
  localparam int SCORE_W     = 7;
  localparam int EVAL_CYCLES = 4;

  localparam int CLS_W      = $clog2(N_CLASS);
  localparam int ROW_CNT_W  = $clog2(IMG_H);
  localparam int EVAL_CNT_W = $clog2(EVAL_CYCLES + 1);

  typedef logic [SCORE_W-1:0] score_t;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    EVAL   = 2'd1,
    RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/bnn_argmax.sv
// Combinational argmax over the BNN class scores; unsigned compare, ties go
// to the lowest class index (all-equal scores give class 0).
module bnn_argmax
  import bnn_seq_pkg::*;
(
  input  logic [N_CLASS-1:0][SCORE_W-1:0] scores,
  output logic [CLS_W-1:0]                max_class,
  output score_t                          max_score
);

  // Strict '>' keeps the earliest index on a tie.
  always_comb begin
    max_class = '0;
    max_score = scores[0];
    for (int i = 1; i < N_CLASS; i++) begin
      if (scores[i] > max_score) begin
        max_class = CLS_W'(i);
        max_score = scores[i];
      end
    end
  end

endmodule

// File: rtl/bnn_frame_sequencer.sv
// I/O shell around the combinational BNN: loads a frame row by row, holds it for
// EVAL_CYCLES, then returns the argmax result. `define BNN_SEQ_SCORES_EN adds res_scores_o.
module bnn_frame_sequencer
  import bnn_seq_pkg::*;
(
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, result outputs hold while stalled.
  input  logic                                 row_valid_i,
  output logic                                 row_ready_o,
  input  logic [IMG_W-1:0]                     row_data_i,
  output logic [0:0][IMG_H-1:0][IMG_W-1:0]     frame_o,
  input  logic [N_CLASS-1:0][SCORE_W-1:0]      score_i,
  output logic                                 res_valid_o,
  input  logic                                 res_ready_i,
  output logic [CLS_W-1:0]                     res_class_o,
  output logic [SCORE_W-1:0]                   res_score_o,
`ifdef BNN_SEQ_SCORES_EN
  output logic [N_CLASS-1:0][SCORE_W-1:0]      res_scores_o,
`endif
  output logic                                 busy_o,
  output state_t                               state_o
);

  state_t                  state, state_n;
  logic [ROW_CNT_W-1:0]    row_cnt;
  logic [EVAL_CNT_W-1:0]   eval_cnt;
  logic                    row_hs;
  logic                    last_row;
  logic                    eval_done;
  logic [CLS_W-1:0]        max_class;
  score_t                  max_score;

  bnn_argmax u_argmax (
    .scores    (score_i),
    .max_class (max_class),
    .max_score (max_score)
  );

  assign last_row  = (row_cnt == ROW_CNT_W'(IMG_H - 1));
  assign row_hs    = (state == LOAD) && row_valid_i;
  assign eval_done = (state == EVAL) && (eval_cnt == EVAL_CNT_W'(EVAL_CYCLES - 1));
  assign state_o   = state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= LOAD;
    else         state <= state_n;
  end

  always_comb begin
    state_n     = state;
    row_ready_o = 1'b0;
    res_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state)
      LOAD: begin
        row_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (row_hs && last_row) state_n = EVAL;
      end
      EVAL: begin
        if (eval_done) state_n = RESULT;
      end
      RESULT: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_n = LOAD;
      end
      default: state_n = LOAD;
    endcase
  end

  // Frame rows not rewritten keep the previous frame's contents; reset clears all.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_o     <= '0;
      row_cnt     <= '0;
      eval_cnt    <= '0;
      res_class_o <= '0;
      res_score_o <= '0;
`ifdef BNN_SEQ_SCORES_EN
      res_scores_o <= '0;
`endif
    end else begin
      if (row_hs) begin
        frame_o[0][row_cnt] <= row_data_i;
        if (last_row) begin
          row_cnt  <= '0;
          eval_cnt <= '0;
        end else begin
          row_cnt <= row_cnt + 1'b1;
        end
      end
      if (state == EVAL) eval_cnt <= eval_cnt + 1'b1;
      if (eval_done) begin
        res_class_o <= max_class;
        res_score_o <= max_score;
`ifdef BNN_SEQ_SCORES_EN
        res_scores_o <= score_i;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bnn_frame_sequencer.sv
// Self-checking bench for bnn_frame_sequencer: scoreboard of expected results,
// frame model, latency/backpressure/abort checks. Honours `define BNN_SEQ_SCORES_EN.
module tb_bnn_frame_sequencer;
  import bnn_seq_pkg::*;

  localparam int EXP_W = CLS_W + SCORE_W + N_CLASS * SCORE_W;

  logic                                clk;
  logic                                rst_n;
  logic                                row_valid;
  logic                                row_ready;
  logic [IMG_W-1:0]                    row_data;
  logic [0:0][IMG_H-1:0][IMG_W-1:0]    frame;
  logic [N_CLASS-1:0][SCORE_W-1:0]     score;
  logic                                res_valid;
  logic                                res_ready;
  logic [CLS_W-1:0]                    res_class;
  logic [SCORE_W-1:0]                  res_score;
`ifdef BNN_SEQ_SCORES_EN
  logic [N_CLASS-1:0][SCORE_W-1:0]     res_scores;
`endif
  logic                                busy;
  state_t                              state;

  bnn_frame_sequencer dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .row_valid_i (row_valid),
    .row_ready_o (row_ready),
    .row_data_i  (row_data),
    .frame_o     (frame),
    .score_i     (score),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_class_o (res_class),
    .res_score_o (res_score),
`ifdef BNN_SEQ_SCORES_EN
    .res_scores_o(res_scores),
`endif
    .busy_o      (busy),
    .state_o     (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [IMG_W-1:0] exp_frame [IMG_H];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [EXP_W-1:0] model(input score_t s0, input score_t s1, input score_t s2);
    score_t           mx;
    logic [CLS_W-1:0] cls;
    mx  = s0;
    if (s1 > mx) mx = s1;
    if (s2 > mx) mx = s2;
    cls = (s0 == mx) ? CLS_W'(0) : (s1 == mx) ? CLS_W'(1) : CLS_W'(2);
    return {cls, mx, s2, s1, s0};
  endfunction

  task automatic check_frame(input string tag);
    for (int r = 0; r < IMG_H; r++) check(tag, frame[0][r], exp_frame[r]);
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_row(input logic [IMG_W-1:0] d);
    bit hs;
    bit ok;
    ok        = 1'b0;
    row_valid = 1'b1;
    row_data  = d;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      hs = row_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    row_valid = 1'b0;
    if (!ok) check("row_timeout", 64'd0, 64'd1);
  endtask

  task automatic load_rows(input int n, input int mode, input bit bubbles);
    logic [IMG_W-1:0] d;
    for (int r = 0; r < n; r++) begin
      if (bubbles && $urandom_range(0, 2) == 0) begin
        row_data = {$urandom, $urandom};
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      d = (mode == 0) ? IMG_W'(r & 15) : {$urandom, $urandom};
      send_row(d);
      exp_frame[r] = d;
    end
  endtask

  task automatic collect_result(input int stall, input bit tie_high);
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    if (!tie_high) res_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      check("stall_valid", res_valid, 1);
      check("stall_class", res_class, e[EXP_W-1 -: CLS_W]);
      check("stall_score", res_score, e[EXP_W-CLS_W-1 -: SCORE_W]);
      check("stall_row_ready", row_ready, 0);
      row_valid = 1'b1;
      row_data  = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    row_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check("res_valid", res_valid, 1);
    check("res_class", res_class, e[EXP_W-1 -: CLS_W]);
    check("res_score", res_score, e[EXP_W-CLS_W-1 -: SCORE_W]);
`ifdef BNN_SEQ_SCORES_EN
    check("res_scores", res_scores, e[N_CLASS*SCORE_W-1:0]);
`endif
    check("hs_row_ready", row_ready, 0);
    @(posedge clk);
    #1;
    if (!tie_high) res_ready = 1'b0;
    check("post_hs_row_ready", row_ready, 1);
    check("post_hs_valid", res_valid, 0);
    check_frame("frame_after_result");
  endtask

  task automatic run_frame(input score_t s0, input score_t s1, input score_t s2,
                           input int mode, input bit bubbles, input int stall,
                           input bit tie_high);
    int n;
    score[0] = s0;
    score[1] = s1;
    score[2] = s2;
    exp_q.push_back(model(s0, s1, s2));
    load_rows(IMG_H, mode, bubbles);
    check_frame("frame_loaded");
    row_valid = 1'b1;
    row_data  = {$urandom, $urandom};
    n = 1;
    while (res_valid !== 1'b1 && n < 20) begin
      check("eval_row_ready", row_ready, 0);
      check("eval_busy", busy, 1);
      @(posedge clk);
      #1;
      n++;
    end
    row_valid = 1'b0;
    check("latency", n, EVAL_CYCLES + 1);
    check("result_busy", busy, 1);
    check_frame("frame_held");
    collect_result(stall, tie_high);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    row_valid = 1'b0;
    row_data  = '0;
    score     = '0;
    res_ready = 1'b0;
    for (int r = 0; r < IMG_H; r++) exp_frame[r] = '0;

    // Reset values with random inputs
    repeat (4) begin
      @(posedge clk);
      #1;
      row_valid = 1'($urandom_range(0, 1));
      row_data  = {$urandom, $urandom};
      score     = N_CLASS*SCORE_W'($urandom);
      res_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_frame_nz", 64'(|frame), 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_class", res_class, 0);
      check("rst_res_score", res_score, 0);
      check("rst_busy", busy, 0);
      check("rst_state", state, LOAD);
    end
    @(posedge clk);
    #1;
    row_valid = 1'b0;
    res_ready = 1'b0;
    rst_n     = 1'b1;
    check("ready_after_rst", row_ready, 1);

    // Nominal frame
    run_frame(7'd5, 7'd40, 7'd12, 0, 1'b0, 0, 1'b0);
    // Ties and backpressure, with input bubbles
    run_frame(7'd9, 7'd9, 7'd3, 1, 1'b1, 10, 1'b0);
    run_frame(7'd0, 7'd0, 7'd0, 1, 1'b1, 3, 1'b0);
    run_frame(7'd3, 7'd7, 7'd7, 1, 1'b0, 1, 1'b0);
    run_frame(7'd126, 7'd0, 7'd127, 1, 1'b1, 0, 1'b0);

    // Abort during LOAD after 30 rows
    load_rows(30, 1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_frame_nz", 64'(|frame), 0);
    check("abort_state", state, LOAD);
    for (int r = 0; r < IMG_H; r++) exp_frame[r] = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_frame(7'd20, 7'd10, 7'd30, 1, 1'b0, 2, 1'b0);

    // Abort with a pending result: it must be dropped
    score[0] = 7'd1;
    score[1] = 7'd2;
    score[2] = 7'd3;
    load_rows(IMG_H, 1, 1'b0);
    repeat (EVAL_CYCLES + 1) begin
      @(posedge clk);
      #1;
    end
    check("pending_valid", res_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("drop_valid", res_valid, 0);
    check("drop_class", res_class, 0);
    check("drop_score", res_score, 0);
    check("drop_frame_nz", 64'(|frame), 0);
    for (int r = 0; r < IMG_H; r++) exp_frame[r] = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back frames, res_ready tied high
    res_ready = 1'b1;
    for (int f = 0; f < 2; f++)
      run_frame(score_t'($urandom), score_t'($urandom), score_t'($urandom), 1, 1'b0, 0, 1'b1);
    res_ready = 1'b0;

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1);
  end

endmodule
